// File: rtl/seq_detect_param.sv
// ============================================================================
// Module   : seq_detect_param
// Purpose  : Serial MSB-first detector for a runtime-loadable PAT_W-bit
//            pattern, with overlap control and a saturating match counter.
//            Define SEQ_DETECT_MASK_EN to add a per-bit don't-care mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_param #(
  parameter int                 PAT_W   = 8,
  parameter logic [PAT_W-1:0]   PAT_RST = PAT_W'(8'b1101_1001),
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_valid,
  input  logic               data,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_W-1:0]   pat_in,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_W-1:0]   mask_in,
  output logic [PAT_W-1:0]   mask,
`endif
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   det_count,
  output logic               armed,
  output logic [PAT_W-1:0]   pattern
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              det_q, det_d;
  logic              armed_q, armed_d;

  logic [PAT_W-1:0]  next_hist;
  logic [FILL_W-1:0] next_fill;
  logic [PAT_W-1:0]  cmp_mask;
  logic              match;
  logic              unused_hist_msb;

`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0]  mask_q, mask_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (pat_load) begin
      mask_d = mask_in;
    end
  end

  assign cmp_mask = mask_q;
  assign mask     = mask_q;
`else
  assign cmp_mask = '1;
`endif

  // The oldest history bit only ever shifts out; the compare uses next_hist.
  assign unused_hist_msb = hist_q[PAT_W-1];

  assign next_hist = {hist_q[PAT_W-2:0], data};
  assign next_fill = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign match     = data_valid && !pat_load && (next_fill == FILL_FULL) &&
                     (((next_hist ^ pattern_q) & cmp_mask) == '0);

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    det_d     = match;

    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (data_valid) begin
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = next_hist;
        fill_d = next_fill;
      end
    end

    // Clear first so a coincident match leaves the count at one.
    if (cnt_clr) begin
      cnt_d = '0;
    end
    if (match && (cnt_d != CNT_MAX)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end

    armed_d = (fill_d == FILL_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern_q <= PAT_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      det_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      det_q     <= det_d;
      armed_q   <= armed_d;
    end
  end

  assign detected  = det_q;
  assign det_count = cnt_q;
  assign armed     = armed_q;
  assign pattern   = pattern_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ============================================================================
// Module   : tb_seq_detect_param
// Purpose  : Self-checking bench for seq_detect_param (CNT_W=8 and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_param;

  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_valid = 1'b0;
  logic          data = 1'b0;
  logic          overlap = 1'b0;
  logic          pat_load = 1'b0;
  logic [PW-1:0] pat_in = '0;
  logic          cnt_clr = 1'b0;

  logic          det8, det2, armed8, armed2;
  logic [7:0]    cnt8;
  logic [1:0]    cnt2;
  logic [PW-1:0] pat8, pat2;
`ifdef SEQ_DETECT_MASK_EN
  logic [PW-1:0] mask8, mask2;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: bits received since the last clear, newest at the back.
  bit            m_win[$];
  logic [PW-1:0] m_pat = 8'hD9;
  int            m_cnt8 = 0;
  int            m_cnt2 = 0;
  logic          m_det = 1'b0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PW), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECT_MASK_EN
    .mask_in({PW{1'b1}}), .mask(mask8),
`endif
    .cnt_clr(cnt_clr), .detected(det8), .det_count(cnt8),
    .armed(armed8), .pattern(pat8)
  );

  seq_detect_param #(.PAT_W(PW), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECT_MASK_EN
    .mask_in({PW{1'b1}}), .mask(mask2),
`endif
    .cnt_clr(cnt_clr), .detected(det2), .det_count(cnt2),
    .armed(armed2), .pattern(pat2)
  );

  function automatic logic window_hit();
    logic [PW-1:0] w;
    w = '0;
    if (m_win.size() != PW) return 1'b0;
    foreach (m_win[i]) w = {w[PW-2:0], m_win[i]};
    return w == m_pat;
  endfunction

  task automatic model_edge();
    logic hit;
    hit = 1'b0;
    if (!rst) begin
      m_pat = 8'hD9;
      m_win.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      if (pat_load) begin
        m_pat = pat_in;
        m_win.delete();
      end else if (data_valid) begin
        m_win.push_back(data);
        if (m_win.size() > PW) void'(m_win.pop_front());
        hit = window_hit();
        if (hit && !overlap) m_win.delete();
      end
      if (cnt_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
      if (hit) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    m_det = hit;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_det8"},   32'(det8),   32'(m_det));
    chk({tag, "_det2"},   32'(det2),   32'(m_det));
    chk({tag, "_cnt8"},   32'(cnt8),   32'(m_cnt8));
    chk({tag, "_cnt2"},   32'(cnt2),   32'(m_cnt2));
    chk({tag, "_armed"},  32'(armed8), 32'(m_win.size() == PW));
    chk({tag, "_armed2"}, 32'(armed2), 32'(m_win.size() == PW));
    chk({tag, "_pat"},    32'(pat8),   32'(m_pat));
  endtask

  task automatic set_in(logic r, logic v, logic d, logic ov, logic ld,
                        logic [PW-1:0] pin, logic clr);
    rst = r; data_valid = v; data = d; overlap = ov;
    pat_load = ld; pat_in = pin; cnt_clr = clr;
  endtask

  task automatic send_bits(string tag, logic [15:0] bits, int n, logic ov);
    for (int i = n - 1; i >= 0; i--) begin
      set_in(1'b1, 1'b1, bits[i], ov, 1'b0, '0, 1'b0);
      cyc(tag);
    end
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc("rst");
  endtask

  task automatic do_load(logic [PW-1:0] p);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, p, 1'b0);
    cyc("load");
  endtask

  task automatic do_idle(string tag);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(tag);
  endtask

  initial begin
    int k;
    logic [PW-1:0] choices [4];
    choices[0] = 8'hAA; choices[1] = 8'hFF; choices[2] = 8'h00; choices[3] = 8'hD9;

    // Reset state
    do_reset();
    chk("rst_pattern", 32'(pat8), 32'hD9);
    chk("rst_count", 32'(cnt8), 32'd0);

    // Default pattern on consecutive bits
    send_bits("t1", 16'b1101_1001, 8, 1'b1);
    chk("t1_det", 32'(det8), 32'd1);
    chk("t1_cnt", 32'(cnt8), 32'd1);
    chk("t1_armed", 32'(armed8), 32'd1);
    do_idle("t1_idle");
    chk("t1_pulse_end", 32'(det8), 32'd0);

    // Gaps between bits 4 and 5
    do_reset();
    send_bits("t2a", 16'b1101, 4, 1'b1);
    repeat (3) do_idle("t2_gap");
    send_bits("t2b", 16'b1001, 4, 1'b1);
    chk("t2_det", 32'(det8), 32'd1);
    chk("t2_cnt", 32'(cnt8), 32'd1);

    // Overlapping 0xAA
    do_reset();
    do_load(8'hAA);
    send_bits("t3", 16'b10_1010_1010, 10, 1'b1);
    chk("t3_det", 32'(det8), 32'd1);
    chk("t3_cnt", 32'(cnt8), 32'd2);

    // Non-overlapping 0xAA
    do_reset();
    do_load(8'hAA);
    send_bits("t4a", 16'b1010_1010, 8, 1'b0);
    chk("t4_det", 32'(det8), 32'd1);
    chk("t4_armed", 32'(armed8), 32'd0);
    send_bits("t4b", 16'b10, 2, 1'b0);
    chk("t4_cnt", 32'(cnt8), 32'd1);

    // Saturation of the narrow counter, then clear on a match edge
    do_reset();
    do_load(8'hFF);
    send_bits("t5", 16'hFFF, 12, 1'b1);
    chk("t5_cnt8", 32'(cnt8), 32'd5);
    chk("t5_cnt2", 32'(cnt2), 32'd3);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    cyc("t5_clr");
    chk("t5_clr_cnt8", 32'(cnt8), 32'd1);
    chk("t5_clr_cnt2", 32'(cnt2), 32'd1);

    // Reset in the middle of a match
    do_reset();
    do_load(8'h3C);
    send_bits("t6a", 16'b110_1100, 7, 1'b1);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc("t6_rst");
    send_bits("t6b", 16'b1, 1, 1'b1);
    chk("t6_det", 32'(det8), 32'd0);
    chk("t6_pat", 32'(pat8), 32'hD9);
    chk("t6_armed", 32'(armed8), 32'd0);

    // All-zero pattern
    do_load(8'h00);
    send_bits("t7", 16'h0, 8, 1'b1);
    chk("t7_det", 32'(det8), 32'd1);

    // Randomised traffic biased toward the current pattern
    k = 0;
    for (int n = 0; n < 600; n++) begin
      int r;
      logic b;
      r = int'($urandom_range(0, 199));
      b = ($urandom_range(0, 9) == 0) ? 1'($urandom) : m_pat[PW-1-(k % PW)];
      if (r < 2) begin
        set_in(1'b0, 1'b1, b, 1'b0, 1'b0, '0, 1'b0);
      end else if (r < 7) begin
        set_in(1'b1, 1'($urandom), b, 1'b0, 1'b1,
               choices[$urandom_range(0, 3)], 1'($urandom_range(0, 3) == 0));
        k = 0;
      end else begin
        set_in(1'b1, ($urandom_range(0, 3) != 0), b, 1'($urandom), 1'b0,
               PW'($urandom), ($urandom_range(0, 49) == 0));
        if (data_valid) k++;
      end
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised successor to the fixed 8-bit serial sequence detector.
- Detects a runtime-loadable PAT_W-bit pattern in a serial bit stream qualified by a valid strobe, MSB first.
- Supports overlapping and non-overlapping detection and keeps a saturating detection count.
- Sits behind a serial front end and flags frame or sync words to downstream control logic.

Parameters:
- PAT_W, 8, pattern length in bits; legal range 2..32.
- PAT_RST, 8'b1101_1001 (zero-extended or truncated to PAT_W), pattern loaded at reset.
- CNT_W, 8, width of the detection counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-low reset.
- data_valid  in  1  data is a live stream bit this cycle.
- data  in  1  serial bit; the first bit received is compared with pattern MSB.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every valid cycle.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern.
- cnt_clr  in  1  zero the detection counter.
- detected  out  1  one-cycle pulse per match.
- det_count  out  CNT_W  saturating number of matches.
- armed  out  1  history holds PAT_W valid bits since the last reset, load or non-overlap match.
- pattern  out  PAT_W  current pattern register.

Behaviour:
- State: pattern register, PAT_W-bit history shift register, fill counter (0..PAT_W, saturating), det_count, detected register.
- Reset (rst=0 at a rising edge):
  - pattern=PAT_RST, history=0, fill=0, detected=0, det_count=0, armed=0.
  - All other inputs are ignored that cycle.
- Valid cycle (data_valid=1, pat_load=0):
  - next_hist = {history[PAT_W-2:0], data}.
  - fill increments and saturates at PAT_W.
  - Match occurs when next_fill==PAT_W and next_hist==pattern.
- Latency: detected is registered. It is high for exactly the one cycle after the edge that samples the final pattern bit; no combinational path from data to detected.
- Idle cycle (data_valid=0): history and fill hold; detected=0. Gaps in valid do not break a partial match.
- Overlap handling on a match:
  - overlap=1: history keeps next_hist and fill stays PAT_W, so the next valid bit can complete another match. With 1010 on stream 101010, matches occur at bits 4 and 6.
  - overlap=0: history and fill clear to 0 on the match edge. PAT_W new valid bits are needed before the next match.
- armed = (fill==PAT_W), registered.
- pat_load=1:
  - pattern<=pat_in; history and fill clear; detected<=0.
  - data on that cycle is discarded even if data_valid=1.
  - det_count is unaffected.
- cnt_clr=1: det_count<=0. If a match occurs on the same edge, det_count<=1, because the clear is applied before the increment.
- det_count increments by 1 per match and saturates at 2^CNT_W-1; it does not wrap.
- Priority: rst > pat_load > valid-cycle processing. cnt_clr is independent of pat_load.
- An all-zero pattern is legal. It matches once fill reaches PAT_W and the last PAT_W bits are 0.

Optional Feature:
- Macro: SEQ_DETECT_MASK_EN.
- Defined:
  - Adds a mask register (PAT_W bits), input port mask_in (PAT_W), and output port mask (PAT_W).
  - The mask register reset value is all ones; pat_load loads mask_in together with pat_in.
  - Match condition becomes ((next_hist ^ pattern) & mask)==0; a mask bit of 0 is don't-care.
  - The fill requirement is unchanged.
- Undefined: exact compare, no mask ports, and behaviour identical to the mask=all-ones case.

Test Plan:
- Reset, then valid bits 1,1,0,1,1,0,0,1 on consecutive cycles -> detected high for exactly 1 cycle after the 8th bit edge; det_count=1; armed=1 from the 8th edge.
- Same 8 bits with data_valid=0 for 3 cycles between bits 4 and 5 -> single detection after the 8th valid bit; no pulse during the gaps.
- pat_load with pat_in=8'hAA and overlap=1, then stream 1010101010 (10 bits) -> detections after bits 8 and 10; det_count=2.
- Same stream with overlap=0 -> detection after bit 8 only; det_count=1; armed=0 after the match edge.
- CNT_W=2, overlap=1, pattern 8'hFF, 12 consecutive ones -> 5 matches, det_count saturates at 3; then cnt_clr asserted on a match edge -> det_count=1.
- rst=0 asserted after the 7th bit of 1101_1001, then the 8th bit sent -> no detection; pattern=PAT_RST; fill restarts from 0.
